// File: rtl/xadc_capture_pkg.sv
// Shared constants, the DRP read FSM state type and a saturating-counter helper
// for the XADC frame capture engine.
package xadc_capture_pkg;

   localparam int unsigned DRP_ADDR_W  = 7;
   localparam int unsigned DRP_DATA_W  = 16;
   localparam int unsigned XADC_CODE_W = 12;
   localparam int unsigned CNT_W       = 16;

   // XADC status-register addresses of the auxiliary inputs in use
   localparam logic [DRP_ADDR_W-1:0] AUX4 = 7'h14;
   localparam logic [DRP_ADDR_W-1:0] AUX5 = 7'h15;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } rd_state_e;

   // Increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/xadc_drp_reader.sv
// Single-read DRP master: one den pulse per start, then waits for drdy or times out.
// Ports:
//   clk, reset            clock, sync active-high reset
//   start, addr           request a read of addr (only honoured in IDLE)
//   done_c, data_c        drdy seen in WAIT this cycle; MSB-aligned sample
//   timeout_c             WAIT expired this cycle without drdy
//   drp_den, drp_daddr    DRP request (registered)
//   drp_drdy, drp_do      DRP response
module xadc_drp_reader
   import xadc_capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = XADC_CODE_W,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DRP_ADDR_W-1:0] addr,
   output logic                  done_c,
   output logic [SAMPLE_W-1:0]   data_c,
   output logic                  timeout_c,
   output logic                  drp_den,
   output logic [DRP_ADDR_W-1:0] drp_daddr,
   input  logic                  drp_drdy,
   input  logic [DRP_DATA_W-1:0] drp_do
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   rd_state_e             state_q, state_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  den_q, den_d;
   logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
   logic                  unused_do;

   // Low data bits below the kept sample are intentionally discarded
   assign unused_do = ^{1'b0, drp_do};

   // Next state and handshake decode
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      den_d     = 1'b0;
      daddr_d   = daddr_q;
      done_c    = 1'b0;
      timeout_c = 1'b0;
      data_c    = drp_do[DRP_DATA_W-1 -: SAMPLE_W];
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               den_d   = 1'b1;
               daddr_d = addr;
            end
         end
         REQ: begin
            state_d = WAIT;
            tmr_d   = TMR_W'(TIMEOUT - 1);
         end
         WAIT: begin
            // drdy on the final allowed cycle still counts as a good read
            if (drp_drdy) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end else if (tmr_q == '0) begin
               timeout_c = 1'b1;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         den_q   <= 1'b0;
         daddr_q <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         den_q   <= den_d;
         daddr_q <= daddr_d;
      end
   end

   assign drp_den   = den_q;
   assign drp_daddr = daddr_q;

endmodule

// File: rtl/xadc_frame_capture.sv
// XADC DRP-side capture: reads the configured channels on each eoc and publishes
// one coherent frame per eos on a valid/ready stream.
// Optional averaging of 2**AVG_LOG2 complete frames: define XADC_CAPTURE_AVG_EN.
// Ports:
//   clk, reset                       clock, sync active-high reset
//   eoc_in, eos_in, channel_in       XADC status pins
//   drp_den/dwe/daddr/di/drdy/do     DRP port of the xadc_wiz instance
//   frame_valid/ready/data           frame stream, data[k] = channel index k
//   drop_count, incomplete_count     saturating telemetry counters
//   drp_timeout                      sticky DRP timeout flag
module xadc_frame_capture
   import xadc_capture_pkg::*;
#(
   parameter int unsigned                       NUM_CH   = 2,
   parameter logic [NUM_CH-1:0][DRP_ADDR_W-1:0] CH_ADDR  = {AUX5, AUX4},
   parameter int unsigned                       SAMPLE_W = XADC_CODE_W,
   parameter int unsigned                       TIMEOUT  = 64,
   parameter int unsigned                       AVG_LOG2 = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         eoc_in,
   input  logic                         eos_in,
   input  logic [4:0]                   channel_in,
   output logic                         drp_den,
   output logic                         drp_dwe,
   output logic [DRP_ADDR_W-1:0]        drp_daddr,
   output logic [DRP_DATA_W-1:0]        drp_di,
   input  logic                         drp_drdy,
   input  logic [DRP_DATA_W-1:0]        drp_do,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [NUM_CH*SAMPLE_W-1:0]   frame_data,
   output logic [CNT_W-1:0]             drop_count,
   output logic [CNT_W-1:0]             incomplete_count,
   output logic                         drp_timeout
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] frame_t;

   logic              pend_q, pend_d;
   logic [4:0]        ch_q, ch_d;
   logic              busy_q, busy_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] seen_q, seen_d, seen_nx;
   frame_t            shadow_q, shadow_nx;
   logic              valid_q, valid_d;
   frame_t            data_q, data_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  inc_q, inc_d;
   logic              tmo_q, tmo_d;

   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              start;
   logic              rd_done, rd_timeout;
   logic [SAMPLE_W-1:0] rd_data;
   logic              complete;
   logic              publish;
   frame_t            cand;

   // Channel match, lowest index wins on duplicate addresses
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         if (ch_q == CH_ADDR[k][4:0]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

   assign start = pend_q && hit;

   // eoc is accepted only when no read is latched or in flight
   always_comb begin
      pend_d = eoc_in && !pend_q && !busy_q;
      ch_d   = pend_d ? channel_in : ch_q;
      idx_d  = start ? hit_idx : idx_q;
      busy_d = busy_q;
      if (start) begin
         busy_d = 1'b1;
      end else if (rd_done || rd_timeout) begin
         busy_d = 1'b0;
      end
   end

   xadc_drp_reader #(
      .SAMPLE_W (SAMPLE_W),
      .TIMEOUT  (TIMEOUT)
   ) u_reader (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .addr      (CH_ADDR[hit_idx]),
      .done_c    (rd_done),
      .data_c    (rd_data),
      .timeout_c (rd_timeout),
      .drp_den   (drp_den),
      .drp_daddr (drp_daddr),
      .drp_drdy  (drp_drdy),
      .drp_do    (drp_do)
   );

   // Shadow/seen including a capture in this cycle, so eos can see it
   always_comb begin
      seen_nx   = seen_q;
      shadow_nx = shadow_q;
      if (rd_done) begin
         seen_nx[idx_q]   = 1'b1;
         shadow_nx[idx_q] = rd_data;
      end
      complete = eos_in && (&seen_nx);
      seen_d   = eos_in ? '0 : seen_nx;
   end

`ifdef XADC_CAPTURE_AVG_EN
   localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;

   logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [AVG_LOG2-1:0]          avg_cnt_q, avg_cnt_d;

   // Accumulate complete frames; publish the truncated mean every 2**AVG_LOG2
   always_comb begin
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      publish   = 1'b0;
      cand      = shadow_nx;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         acc_sum[k] = acc_q[k] + ACC_W'(shadow_nx[k]);
      end
      if (complete) begin
         if (avg_cnt_q == '1) begin
            publish   = 1'b1;
            acc_d     = '0;
            avg_cnt_d = '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
               cand[k] = SAMPLE_W'(acc_sum[k] >> AVG_LOG2);
            end
         end else begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         avg_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
      end
   end
`else
   assign publish = complete;
   assign cand    = shadow_nx;
`endif

   // Output stream and telemetry
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      drop_d  = drop_q;
      inc_d   = inc_q;
      tmo_d   = tmo_q | rd_timeout;
      if (valid_q && frame_ready) begin
         valid_d = 1'b0;
      end
      if (publish) begin
         if (!valid_q || frame_ready) begin
            valid_d = 1'b1;
            data_d  = cand;
         end else begin
            drop_d = sat_inc(drop_q);
         end
      end
      if (eos_in && !(&seen_nx)) begin
         inc_d = sat_inc(inc_q);
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q   <= 1'b0;
         ch_q     <= '0;
         busy_q   <= 1'b0;
         idx_q    <= '0;
         seen_q   <= '0;
         shadow_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         drop_q   <= '0;
         inc_q    <= '0;
         tmo_q    <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         ch_q     <= ch_d;
         busy_q   <= busy_d;
         idx_q    <= idx_d;
         seen_q   <= seen_d;
         shadow_q <= shadow_nx;
         valid_q  <= valid_d;
         data_q   <= data_d;
         drop_q   <= drop_d;
         inc_q    <= inc_d;
         tmo_q    <= tmo_d;
      end
   end

   assign drp_dwe          = 1'b0;
   assign drp_di           = '0;
   assign frame_valid      = valid_q;
   assign frame_data       = data_q;
   assign drop_count       = drop_q;
   assign incomplete_count = inc_q;
   assign drp_timeout      = tmo_q;

endmodule

// File: doc/xadc_frame_capture.md
Name: xadc_frame_capture

Overview:
- Parametrised XADC DRP-side capture engine.
- Reads N configured XADC status channels on each end-of-conversion and assembles them into one coherent frame per end-of-sequence.
- Presents frames on a valid/ready stream to the trigger/acquisition logic.
- Connects directly to the DRP and status pins of the xadc_wiz instance. Frame-drop and DRP-error telemetry go to the control bus.

Parameters:
- NUM_CH, 2: number of captured channels (1..8).
- CH_ADDR, {7'h15, 7'h14}: per-channel DRP status address, packed [NUM_CH-1:0][6:0]. Index 0 is aux4, index 1 is aux5.
- SAMPLE_W, 12: kept bits, taken from DRP data MSBs.
- TIMEOUT, 64: max cycles from den to drdy.
- AVG_LOG2, 2: log2 of frames averaged. Used only with the optional feature.

Ports:
- clk  in  1  system/DRP clock.
- reset  in  1  sync active-high reset.
- eoc_in  in  1  XADC end-of-conversion pulse.
- eos_in  in  1  XADC end-of-sequence pulse.
- channel_in  in  5  XADC channel_out.
- drp_den  out  1  DRP enable, single-cycle pulse.
- drp_dwe  out  1  DRP write enable, always 0.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data, always 0.
- drp_drdy  in  1  DRP data ready.
- drp_do  in  16  DRP read data.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts.
- frame_data  out  NUM_CH*SAMPLE_W  packed [NUM_CH-1:0][SAMPLE_W-1:0], index = channel index.
- drop_count  out  16  saturating count of completed frames dropped due to backpressure.
- incomplete_count  out  16  saturating count of eos with missing channels.
- drp_timeout  out  1  sticky; set on DRP timeout.

Behaviour:
- Reset clk/reset: reset sync, active-high; clock clk.
- Reset values:
  - all outputs 0.
  - state IDLE, seen mask 0, shadow samples 0.
  - counters 0, drp_timeout 0.
- Read FSM states: IDLE, REQ, WAIT.
- IDLE:
  - on eoc_in, latch channel_in and compare it against every CH_ADDR[k][4:0].
  - on a match, go to REQ with index k; otherwise stay in IDLE.
- REQ (1 cycle):
  - drp_den=1, drp_daddr=CH_ADDR[k], drp_dwe=0.
  - go to WAIT, load timeout counter.
- WAIT:
  - on drp_drdy, shadow[k] <= drp_do[15 -: SAMPLE_W], set seen[k], go to IDLE.
  - after TIMEOUT cycles without drdy, set drp_timeout and go to IDLE; seen[k] is not set.
- eoc_in while not in IDLE is ignored (no queueing).
- Latency: eoc to den is 2 cycles.
- On eos_in, evaluate seen_next, which includes a drdy capture occurring in the same cycle:
  - all NUM_CH bits set: frame complete.
    - If the output is empty (frame_valid==0, or frame_valid&&frame_ready this cycle), load frame_data and assert frame_valid next cycle.
    - Otherwise keep the old frame and increment drop_count.
  - not all set: increment incomplete_count; no frame.
  - seen is cleared in both cases.
- Same-channel re-read before eos overwrites shadow (last value wins).
- Stream rules:
  - frame_data is stable while frame_valid && !frame_ready.
  - frame_valid drops the cycle after acceptance unless a new frame loads in the same cycle.
- All counters saturate at 16'hFFFF.
- drp_timeout is cleared only by reset.
- Reset mid-WAIT: return to IDLE immediately; a late drdy after reset is ignored.

Optional Feature:
- Macro XADC_CAPTURE_AVG_EN.
- Defined:
  - per-channel accumulators of width SAMPLE_W+AVG_LOG2.
  - each complete frame is added in; frames with missing channels are not.
  - after 2**AVG_LOG2 complete frames, the publish candidate is acc>>AVG_LOG2 (truncated), then the accumulators clear.
  - drop/valid rules apply to the averaged frame only.
- Undefined: every complete frame is published; AVG_LOG2 is unused; no accumulator logic.

Decomposition:
- Package xadc_capture_pkg holds:
  - DRP_ADDR_W=7, DRP_DATA_W=16, XADC_CODE_W=12.
  - read FSM state enum.
  - aux channel address constants (AUX4=7'h14, AUX5=7'h15).
  - counter width.
- Sub-module xadc_drp_reader:
  - contains the REQ/WAIT FSM and timeout.
  - interface: start, addr, done, data, timeout.
  - the top handles matching, frame assembly, averaging and the stream.

Test Plan:
1. Default params; eoc with channel 0x14, drdy do=16'hABC0 two cycles after den; eoc 0x15, do=16'h1230; eos -> frame_valid=1, frame_data[0]=12'hABC, [1]=12'h123.
2. frame_ready=0; three complete sequences -> first frame held unchanged, drop_count=2; then ready=1 -> accepted, frame_valid=0.
3. Only channel 0x14 read before eos -> no frame_valid, incomplete_count=1; the next full sequence publishes normally.
4. drp_drdy withheld 70 cycles -> drp_timeout=1, FSM back to IDLE by cycle 65; the next eoc issues den normally.
5. eos in the same cycle as drdy for the last channel -> frame published with the new value; eoc during WAIT is ignored (single den only).
6. With XADC_CAPTURE_AVG_EN, AVG_LOG2=2: ch0 codes 100,101,102,104 -> one frame with ch0=101 after the 4th eos; no frame after eos 1-3.
